control_sequencer: RTL and testbench

- Instruction-phase sequencer and control decoder for the accumulator CPU.
- Owns the instruction register, the FETCH/EXEC1/EXEC2/EXEC3 phase machine, a bounded hardware stack counter with fault detection, and the STP halt state.
- Drives the PC, RAM, multiplexer and accumulator strobes of the datapath.
- Replaces the external phase counter; adds a parametrised stack region and a memory STALL handshake.

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/opcode_decode.sv | 41 ++++
 rtl/control_sequencer.sv | 172 +++++++++++++++++
 tb/tb_control_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode encodings, phase enum and decoded-instruction record for the
// accumulator CPU control sequencer.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_STA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JMI  = 4'h6;
  localparam logic [3:0] OP_JEQ  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LDN  = 4'h9;
  localparam logic [3:0] OP_SSS  = 4'hA;
  localparam logic [3:0] OP_JME  = 4'hB;
  localparam logic [3:0] OP_JMG  = 4'hC;
  localparam logic [3:0] OP_JGE  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  localparam logic [3:0] SUB_STP  = 4'h0;
  localparam logic [3:0] SUB_PUSH = 4'h7;
  localparam logic [3:0] SUB_POP  = 4'h8;
  localparam logic [3:0] SUB_INC  = 4'hA;
  localparam logic [3:0] SUB_DEC  = 4'hB;

  localparam int CMP_EQ = 0;
  localparam int CMP_GT = 1;
  localparam int CMP_GE = 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    EXEC3 = 2'd3
  } phase_e;

  // One line per instruction; SSS sub-ops get their own lines, sss is set for all of them.
  typedef struct packed {
    logic lda, sta, add, sub, mul, jmp, jmi, jeq;
    logic ldi, ldn, sss, jme, jmg, jge, call, ret;
    logic stp, push, pop, inc, dec, nop;
  } instr_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational decode of the instruction register into one-hot instruction lines.
module opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output instr_t     instr
);

  always_comb begin
    instr = '0;
    case (ir[7:4])
      OP_LDA:  instr.lda  = 1'b1;
      OP_STA:  instr.sta  = 1'b1;
      OP_ADD:  instr.add  = 1'b1;
      OP_SUB:  instr.sub  = 1'b1;
      OP_MUL:  instr.mul  = 1'b1;
      OP_JMP:  instr.jmp  = 1'b1;
      OP_JMI:  instr.jmi  = 1'b1;
      OP_JEQ:  instr.jeq  = 1'b1;
      OP_LDI:  instr.ldi  = 1'b1;
      OP_LDN:  instr.ldn  = 1'b1;
      OP_JME:  instr.jme  = 1'b1;
      OP_JMG:  instr.jmg  = 1'b1;
      OP_JGE:  instr.jge  = 1'b1;
      OP_CALL: instr.call = 1'b1;
      OP_RET:  instr.ret  = 1'b1;
      default: begin
        instr.sss = 1'b1;
        case (ir[3:0])
          SUB_STP:  instr.stp  = 1'b1;
          SUB_PUSH: instr.push = 1'b1;
          SUB_POP:  instr.pop  = 1'b1;
          SUB_INC:  instr.inc  = 1'b1;
          SUB_DEC:  instr.dec  = 1'b1;
          default:  instr.nop  = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction-phase sequencer and control decoder: phase FSM, IR, bounded stack
// counter with overflow/underflow fault, halt state and datapath strobes.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                SP_W       = 4,
  parameter logic [ADDR_W-1:0] STACK_BASE = '1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        IR_in,
  input  logic              STALL,
  input  logic              EQ,
  input  logic              MI,
  input  logic [2:0]        CMPFlag,
  output logic [1:0]        PHASE,
  output logic              IR_load,
  output logic              PC_sync_load,
  output logic              PC_count_enable,
  output logic              RAM_write_enable,
  output logic              MUX1_select,
  output logic              MUX2sel,
  output logic              MUXLsel,
  output logic              SpMux,
  output logic              ACC_load,
  output logic              LDN_sel,
  output logic [ADDR_W-1:0] SP_addr,
  output logic              HALTED,
  output logic              STACK_FAULT
);

  localparam logic [SP_W:0] DEPTH   = {1'b1, {SP_W{1'b0}}};
  localparam logic [SP_W:0] CNT_ONE = {{SP_W{1'b0}}, 1'b1};

  phase_e        phase, phase_nxt;
  logic [7:0]    ir, ir_nxt;
  logic [SP_W:0] cnt, cnt_nxt;
  logic          halted, halted_nxt;
  logic          stack_fault, fault_nxt;

  instr_t        d;
  logic          is_cond, taken, stk_push, stk_pop, overflow, underflow, fault_now, pop_rd;
  logic [SP_W:0] sp_off;

  opcode_decode u_decode (
    .ir    (ir),
    .instr (d)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase       <= FETCH;
      ir          <= '0;
      cnt         <= '0;
      halted      <= 1'b0;
      stack_fault <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      ir          <= ir_nxt;
      cnt         <= cnt_nxt;
      halted      <= halted_nxt;
      stack_fault <= fault_nxt;
    end
  end

  assign is_cond   = d.jmi | d.jeq | d.jme | d.jmg | d.jge;
  assign taken     = (d.jmi & MI) | (d.jeq & EQ) | (d.jme & CMPFlag[CMP_EQ])
                   | (d.jmg & CMPFlag[CMP_GT]) | (d.jge & CMPFlag[CMP_GE]);
  assign stk_push  = d.push | d.call;
  assign stk_pop   = d.pop | d.ret;
  assign overflow  = stk_push & (cnt == DEPTH);
  assign underflow = stk_pop & (cnt == '0);
  assign fault_now = (phase == EXEC1) & ~halted & (overflow | underflow);

  // A pop addresses the entry just below the counter; a faulting pop reads nothing.
  assign pop_rd  = (phase == EXEC1) & ~halted & stk_pop & ~underflow;
  assign sp_off  = pop_rd ? (cnt - CNT_ONE) : cnt;
  assign SP_addr = STACK_BASE - ADDR_W'(sp_off);

  assign PHASE       = phase;
  assign HALTED      = halted;
  assign STACK_FAULT = stack_fault;

  always_comb begin
    phase_nxt        = phase;
    ir_nxt           = ir;
    cnt_nxt          = cnt;
    halted_nxt       = halted;
    fault_nxt        = stack_fault;
    IR_load          = 1'b0;
    PC_sync_load     = 1'b0;
    PC_count_enable  = 1'b0;
    RAM_write_enable = 1'b0;
    MUX1_select      = 1'b0;
    MUX2sel          = 1'b0;
    MUXLsel          = 1'b0;
    SpMux            = 1'b0;
    ACC_load         = 1'b0;
    LDN_sel          = d.ldn & ~halted;

    if (!halted) begin
      case (phase)
        FETCH: begin
          IR_load   = 1'b1;
          ir_nxt    = IR_in;
          phase_nxt = EXEC1;
        end
        EXEC1: begin
          MUX2sel     = 1'b1;
          MUX1_select = d.lda | d.sta | d.add | d.sub | d.mul | d.ldn | d.ret;
          SpMux       = stk_push | stk_pop;
          if (fault_now) begin
            fault_nxt  = 1'b1;
            halted_nxt = 1'b1;
            phase_nxt  = FETCH;
          end else begin
            PC_sync_load     = d.jmp | d.call | (is_cond & taken);
            PC_count_enable  = d.lda | d.sta | d.add | d.sub | d.mul | d.ldi | d.ldn
                             | (is_cond & ~taken) | (d.sss & ~d.stp);
            RAM_write_enable = d.sta | stk_push;
            ACC_load         = d.lda | d.add | d.sub | d.mul | d.pop | d.inc | d.dec;
            if (stk_push) cnt_nxt = cnt + CNT_ONE;
            if (stk_pop)  cnt_nxt = cnt - CNT_ONE;
            halted_nxt = d.stp;
            phase_nxt  = (d.ldn | d.ret) ? EXEC2 : FETCH;
          end
        end
        EXEC2: begin
          MUX1_select  = d.ldn;
          MUX2sel      = d.ldn;
          MUXLsel      = d.ldn;
          PC_sync_load = d.ret;
          phase_nxt    = d.ldn ? EXEC3 : FETCH;
        end
        EXEC3: begin
          MUXLsel   = d.ldn;
          ACC_load  = d.ldn;
          phase_nxt = FETCH;
        end
      endcase
    end

    // A stall freezes all state, including a pending fault, and drops the strobes.
    if (STALL) begin
      phase_nxt        = phase;
      ir_nxt           = ir;
      cnt_nxt          = cnt;
      halted_nxt       = halted;
      fault_nxt        = stack_fault;
      IR_load          = 1'b0;
      PC_sync_load     = 1'b0;
      PC_count_enable  = 1'b0;
      RAM_write_enable = 1'b0;
      ACC_load         = 1'b0;
    end

    if (RESET) begin
      IR_load          = 1'b0;
      PC_sync_load     = 1'b0;
      PC_count_enable  = 1'b0;
      RAM_write_enable = 1'b0;
      MUX1_select      = 1'b0;
      MUX2sel          = 1'b0;
      MUXLsel          = 1'b0;
      SpMux            = 1'b0;
      ACC_load         = 1'b0;
      LDN_sel          = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-level bench for control_sequencer with a 4-entry stack at the top of RAM.
module tb_control_sequencer;

  localparam logic [1:0] P_F  = 2'd0;
  localparam logic [1:0] P_E1 = 2'd1;
  localparam logic [1:0] P_E2 = 2'd2;
  localparam logic [1:0] P_E3 = 2'd3;

  localparam logic [11:0] IRL  = 12'h800;
  localparam logic [11:0] PCS  = 12'h400;
  localparam logic [11:0] PCC  = 12'h200;
  localparam logic [11:0] RAMW = 12'h100;
  localparam logic [11:0] MUX1 = 12'h080;
  localparam logic [11:0] MUX2 = 12'h040;
  localparam logic [11:0] MUXL = 12'h020;
  localparam logic [11:0] SPM  = 12'h010;
  localparam logic [11:0] ACC  = 12'h008;
  localparam logic [11:0] LDN  = 12'h004;
  localparam logic [11:0] HLT  = 12'h002;
  localparam logic [11:0] FLT  = 12'h001;

  logic       CLK, RESET, STALL, EQ, MI;
  logic [7:0] IR_in;
  logic [2:0] CMPFlag;
  logic [1:0] PHASE;
  logic       IR_load, PC_sync_load, PC_count_enable, RAM_write_enable;
  logic       MUX1_select, MUX2sel, MUXLsel, SpMux, ACC_load, LDN_sel;
  logic [7:0] SP_addr;
  logic       HALTED, STACK_FAULT;

  logic [21:0] obs;
  logic [21:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  control_sequencer #(.ADDR_W(8), .SP_W(2), .STACK_BASE(8'hFF)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .IR_in            (IR_in),
    .STALL            (STALL),
    .EQ               (EQ),
    .MI               (MI),
    .CMPFlag          (CMPFlag),
    .PHASE            (PHASE),
    .IR_load          (IR_load),
    .PC_sync_load     (PC_sync_load),
    .PC_count_enable  (PC_count_enable),
    .RAM_write_enable (RAM_write_enable),
    .MUX1_select      (MUX1_select),
    .MUX2sel          (MUX2sel),
    .MUXLsel          (MUXLsel),
    .SpMux            (SpMux),
    .ACC_load         (ACC_load),
    .LDN_sel          (LDN_sel),
    .SP_addr          (SP_addr),
    .HALTED           (HALTED),
    .STACK_FAULT      (STACK_FAULT)
  );

  assign obs = {PHASE, IR_load, PC_sync_load, PC_count_enable, RAM_write_enable,
                MUX1_select, MUX2sel, MUXLsel, SpMux, ACC_load, LDN_sel,
                HALTED, STACK_FAULT, SP_addr};

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [21:0] act, input logic [21:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got phase=%0d strobes=%h sp=%h, expected phase=%0d strobes=%h sp=%h",
               tag, act[21:20], act[19:8], act[7:0], exp[21:20], exp[19:8], exp[7:0]);
    else
      n_pass++;
  endtask

  // Drives one cycle of inputs, queues the expected outputs, compares at the falling edge.
  task automatic step(input logic [7:0] ir_v, input logic stall_v, input logic [1:0] ph,
                      input logic [11:0] fl, input logic [7:0] addr, input string tag);
    logic [21:0] e;
    IR_in = ir_v;
    STALL = stall_v;
    exp_q.push_back({ph, fl, addr});
    @(negedge CLK);
    e = exp_q.pop_front();
    check_eq(tag, obs, e);
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    step(8'h00, 1'b0, P_F, 12'h000, 8'hFF, "reset_pulse");
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; EQ = 1'b0; MI = 1'b0; CMPFlag = 3'b000; IR_in = 8'h00;
    @(posedge CLK);
    #1;
    step(8'h55, 1'b0, P_F, 12'h000, 8'hFF, "reset_hold");
    step(8'h55, 1'b1, P_F, 12'h000, 8'hFF, "reset_hold_stall");
    RESET = 1'b0;

    step(8'h05, 1'b0, P_F,  IRL,                     8'hFF, "lda_fetch");
    step(8'h05, 1'b0, P_E1, MUX1 | MUX2 | PCC | ACC, 8'hFF, "lda_exec1");

    step(8'h70, 1'b0, P_F,  IRL,        8'hFF, "jeq_fetch");
    step(8'h70, 1'b0, P_E1, MUX2 | PCC, 8'hFF, "jeq_not_taken");
    step(8'h70, 1'b0, P_F,  IRL,        8'hFF, "jeq_fetch2");
    EQ = 1'b1;
    step(8'h70, 1'b0, P_E1, MUX2 | PCS, 8'hFF, "jeq_taken");
    EQ = 1'b0;

    step(8'hC0, 1'b0, P_F,  IRL,        8'hFF, "jmg_fetch");
    CMPFlag = 3'b010;
    step(8'hC0, 1'b0, P_E1, MUX2 | PCS, 8'hFF, "jmg_taken");
    CMPFlag = 3'b000;
    step(8'hC0, 1'b0, P_F,  IRL,        8'hFF, "jmg_fetch2");
    CMPFlag = 3'b101;
    step(8'hC0, 1'b0, P_E1, MUX2 | PCC, 8'hFF, "jmg_not_taken");
    CMPFlag = 3'b000;

    step(8'h60, 1'b0, P_F,  IRL,        8'hFF, "jmi_fetch");
    MI = 1'b1;
    step(8'h60, 1'b0, P_E1, MUX2 | PCS, 8'hFF, "jmi_taken");
    MI = 1'b0;

    step(8'h90, 1'b0, P_F,  IRL,                      8'hFF, "ldn_fetch");
    step(8'h90, 1'b0, P_E1, MUX1 | MUX2 | PCC | LDN,  8'hFF, "ldn_exec1");
    step(8'h90, 1'b0, P_E2, MUX1 | MUX2 | MUXL | LDN, 8'hFF, "ldn_exec2");
    step(8'h90, 1'b0, P_E3, MUXL | ACC | LDN,         8'hFF, "ldn_exec3");

    for (int i = 0; i < 4; i++) begin
      step(8'hA7, 1'b0, P_F,  IRL | ((i == 0) ? LDN : 12'h000), 8'hFF - 8'(i), "push_fetch");
      step(8'hA7, 1'b0, P_E1, MUX2 | SPM | RAMW | PCC,          8'hFF - 8'(i), "push_exec1");
    end
    step(8'hA7, 1'b0, P_F,  IRL,        8'hFB, "push5_fetch");
    step(8'hA7, 1'b1, P_E1, MUX2 | SPM, 8'hFB, "push5_ovf_stalled");
    step(8'hA7, 1'b0, P_E1, MUX2 | SPM, 8'hFB, "push5_ovf");
    step(8'hA7, 1'b0, P_F,  HLT | FLT,  8'hFB, "ovf_halted");
    step(8'h05, 1'b1, P_F,  HLT | FLT,  8'hFB, "ovf_halted2");
    pulse_reset();

    step(8'hE0, 1'b0, P_F,  IRL,                     8'hFF, "call_fetch");
    step(8'hE0, 1'b0, P_E1, MUX2 | SPM | RAMW | PCS, 8'hFF, "call_exec1");
    step(8'hF0, 1'b0, P_F,  IRL,                     8'hFE, "ret_fetch");
    step(8'hF0, 1'b0, P_E1, MUX1 | MUX2 | SPM,       8'hFF, "ret_exec1");
    step(8'hF0, 1'b0, P_E2, PCS,                     8'hFF, "ret_exec2");
    step(8'hF0, 1'b0, P_F,  IRL,                     8'hFF, "ret2_fetch");
    step(8'hF0, 1'b0, P_E1, MUX1 | MUX2 | SPM,       8'hFF, "ret2_udf");
    step(8'h05, 1'b0, P_F,  HLT | FLT,               8'hFF, "udf_halted");
    pulse_reset();

    step(8'hA0, 1'b0, P_F,  IRL,  8'hFF, "stp_fetch");
    step(8'hA0, 1'b0, P_E1, MUX2, 8'hFF, "stp_exec1");
    for (int i = 0; i < 3; i++)
      step(8'h05, 1'(i & 1), P_F, HLT, 8'hFF, "stp_halted");
    pulse_reset();

    step(8'h10, 1'b0, P_F, IRL, 8'hFF, "sta_fetch");
    for (int i = 0; i < 3; i++)
      step(8'h10, 1'b1, P_E1, MUX1 | MUX2, 8'hFF, "sta_stalled");
    step(8'h10, 1'b0, P_E1, MUX1 | MUX2 | PCC | RAMW, 8'hFF, "sta_write");

    step(8'h10, 1'b1, P_F,  12'h000,          8'hFF, "fetch_stalled");
    step(8'hAA, 1'b0, P_F,  IRL,              8'hFF, "inc_fetch");
    step(8'hAA, 1'b0, P_E1, MUX2 | PCC | ACC, 8'hFF, "inc_exec1");

    step(8'hA7, 1'b0, P_F,  IRL,                     8'hFF, "push_fetch_b");
    step(8'hA7, 1'b0, P_E1, MUX2 | SPM | RAMW | PCC, 8'hFF, "push_exec1_b");
    step(8'hA8, 1'b0, P_F,  IRL,                     8'hFE, "pop_fetch");
    step(8'hA8, 1'b0, P_E1, MUX2 | SPM | PCC | ACC,  8'hFF, "pop_exec1");
    step(8'hA3, 1'b0, P_F,  IRL,                     8'hFF, "nop_fetch");
    step(8'hA3, 1'b0, P_E1, MUX2 | PCC,              8'hFF, "nop_exec1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
